// File: rtl/motor_ramp_sequencer_pkg.sv
// Shared encodings and defaults for the motor ramp sequencer.
// Optional feature: define MOTOR_CMD_WDT_EN to build the command watchdog (target forced to 0 after WDT_CYCLES without a command).
package motor_ramp_sequencer_pkg;

    localparam int unsigned DUTY_CYCLE_WIDTH = 10;
    localparam int unsigned STATE_W          = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_RAMP  = 3'd1,
        ST_RUN   = 3'd2,
        ST_DWELL = 3'd3,
        ST_FAULT = 3'd4
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/motor_ramp_sequencer_if.sv
// Command handshake bundle between a motion controller and the motor ramp sequencer.
interface motor_ramp_sequencer_if #(
    parameter int unsigned DUTY_W = motor_ramp_sequencer_pkg::DUTY_CYCLE_WIDTH
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [DUTY_W-1:0] cmd_duty;
    logic              cmd_dir;

    modport master (output cmd_valid, output cmd_duty, output cmd_dir, input  cmd_ready);
    modport slave  (input  cmd_valid, input  cmd_duty, input  cmd_dir, output cmd_ready);
endinterface

// File: rtl/motor_ramp_sequencer_ramp_tick_gen.sv
// Ramp prescaler: free-running divide-by-DIV counter, held at zero while clear_i is high.
module ramp_tick_gen
    import motor_ramp_sequencer_pkg::*;
#(
    parameter int unsigned DIV = 250
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    output logic tick_c_o
);
    localparam int unsigned     CNT_W = cnt_width(DIV);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_c_o = !clear_i && (cnt_q == LAST);

endmodule

// File: rtl/motor_ramp_sequencer.sv
// Ramps motor duty toward the commanded target and dwells at zero duty before reversing direction.
// Optional: define MOTOR_CMD_WDT_EN to add the command watchdog.
module motor_ramp_sequencer
    import motor_ramp_sequencer_pkg::*;
#(
    parameter int unsigned DUTY_W       = DUTY_CYCLE_WIDTH,
    parameter int unsigned RAMP_STEP    = 4,
    parameter int unsigned RAMP_DIV     = 250,
    parameter int unsigned DWELL_CYCLES = 1024,
    parameter int unsigned WDT_CYCLES   = 2000000
) (
    input  logic                   clock,
    input  logic                   reset_n,
    motor_ramp_sequencer_if.slave  cmd,
    input  logic                   fault_in,
    input  logic                   fault_clear,
    output logic [DUTY_W-1:0]      duty_cycle,
    output logic                   dir,
    output logic [STATE_W-1:0]     state,
    output logic                   fault_latched,
    output logic                   wdt_timeout
);
    localparam int unsigned      EXT_W      = DUTY_W + 1;
    localparam int unsigned      DW_W       = cnt_width(DWELL_CYCLES);
    localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(DWELL_CYCLES - 1);
    localparam logic [EXT_W-1:0] STEP_X     = EXT_W'(RAMP_STEP);

    if ((RAMP_DIV < 1) || (DWELL_CYCLES < 1) || (WDT_CYCLES < 1)) begin : g_cfg_check
        $error("motor_ramp_sequencer: RAMP_DIV, DWELL_CYCLES and WDT_CYCLES must be >= 1");
    end

    state_e            state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d;
    logic [DUTY_W-1:0] tgt_duty_q, tgt_duty_d;
    logic              tgt_dir_q, tgt_dir_d;
    logic [DW_W-1:0]   dwell_q, dwell_d;
    logic              fault_latched_q, fault_latched_d;
    logic              tick;
    logic              cmd_accept;
    logic [EXT_W-1:0]  duty_x, tgt_x, up_x;
    logic [DUTY_W-1:0] toward_tgt, toward_zero;

    assign cmd.cmd_ready = reset_n && (state_q != ST_FAULT) && !fault_in;
    assign cmd_accept    = cmd.cmd_valid && cmd.cmd_ready;

    ramp_tick_gen #(.DIV(RAMP_DIV)) u_tick (
        .clk_i    (clock),
        .rst_ni   (reset_n),
        .clear_i  (state_q != ST_RAMP),
        .tick_c_o (tick)
    );

    // One ramp step, computed one bit wider so the step can never wrap.
    assign duty_x = EXT_W'(duty_q);
    assign tgt_x  = EXT_W'(tgt_duty_q);
    assign up_x   = duty_x + STEP_X;

    always_comb begin
        toward_tgt = tgt_duty_q;
        if (duty_x < tgt_x) begin
            toward_tgt = (up_x >= tgt_x) ? tgt_duty_q : DUTY_W'(up_x);
        end else if ((duty_x - tgt_x) > STEP_X) begin
            toward_tgt = DUTY_W'(duty_x - STEP_X);
        end
        toward_zero = (duty_x <= STEP_X) ? '0 : DUTY_W'(duty_x - STEP_X);
    end

`ifdef MOTOR_CMD_WDT_EN
    localparam int unsigned      WDT_W    = cnt_width(WDT_CYCLES);
    localparam logic [WDT_W-1:0] WDT_LAST = WDT_W'(WDT_CYCLES - 1);

    logic [WDT_W-1:0] wdt_q, wdt_d;
    logic             wdt_pulse_q, wdt_pulse_d;

    assign wdt_timeout = wdt_pulse_q;
`else
    assign wdt_timeout = 1'b0;
`endif

    always_comb begin
        state_d         = state_q;
        duty_d          = duty_q;
        dir_d           = dir_q;
        tgt_duty_d      = tgt_duty_q;
        tgt_dir_d       = tgt_dir_q;
        dwell_d         = dwell_q;
`ifdef MOTOR_CMD_WDT_EN
        wdt_d           = wdt_q;
        wdt_pulse_d     = 1'b0;
`endif

        if (cmd_accept) begin
            tgt_duty_d = cmd.cmd_duty;
            tgt_dir_d  = cmd.cmd_dir;
        end

`ifdef MOTOR_CMD_WDT_EN
        // Silence on the command port requests a normal ramp-down to zero.
        if (cmd_accept || (state_q == ST_FAULT)) begin
            wdt_d = '0;
        end else if (wdt_q == WDT_LAST) begin
            wdt_d       = '0;
            wdt_pulse_d = 1'b1;
            tgt_duty_d  = '0;
        end else begin
            wdt_d = wdt_q + WDT_W'(1);
        end
`endif

        case (state_q)
            ST_IDLE, ST_RUN: begin
                if ((tgt_duty_q != duty_q) || (tgt_dir_q != dir_q)) begin
                    state_d = ST_RAMP;
                end
            end
            ST_RAMP: begin
                if (tgt_dir_q != dir_q) begin
                    if (tick) begin
                        duty_d = toward_zero;
                    end
                    if (duty_d == '0) begin
                        state_d = ST_DWELL;
                        dwell_d = '0;
                    end
                end else begin
                    if (tick) begin
                        duty_d = toward_tgt;
                    end
                    if (duty_d == tgt_duty_q) begin
                        state_d = (tgt_duty_q == '0) ? ST_IDLE : ST_RUN;
                    end
                end
            end
            ST_DWELL: begin
                duty_d = '0;
                if (dwell_q == DWELL_LAST) begin
                    dwell_d = '0;
                    dir_d   = tgt_dir_q;
                    state_d = (tgt_duty_q == '0) ? ST_IDLE : ST_RAMP;
                end else begin
                    dwell_d = dwell_q + DW_W'(1);
                end
            end
            ST_FAULT: begin
                if (fault_clear && !fault_in) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A driver fault overrides everything, including a same-edge command.
        if (fault_in) begin
            state_d    = ST_FAULT;
            duty_d     = '0;
            dir_d      = dir_q;
            tgt_duty_d = '0;
            tgt_dir_d  = tgt_dir_q;
            dwell_d    = '0;
        end

        fault_latched_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            duty_q          <= '0;
            dir_q           <= 1'b0;
            tgt_duty_q      <= '0;
            tgt_dir_q       <= 1'b0;
            dwell_q         <= '0;
            fault_latched_q <= 1'b0;
`ifdef MOTOR_CMD_WDT_EN
            wdt_q           <= '0;
            wdt_pulse_q     <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            duty_q          <= duty_d;
            dir_q           <= dir_d;
            tgt_duty_q      <= tgt_duty_d;
            tgt_dir_q       <= tgt_dir_d;
            dwell_q         <= dwell_d;
            fault_latched_q <= fault_latched_d;
`ifdef MOTOR_CMD_WDT_EN
            wdt_q           <= wdt_d;
            wdt_pulse_q     <= wdt_pulse_d;
`endif
        end
    end

    assign duty_cycle    = duty_q;
    assign dir           = dir_q;
    assign state         = state_q;
    assign fault_latched = fault_latched_q;

endmodule

// File: tb/tb_motor_ramp_sequencer.sv
// Directed self-checking bench for motor_ramp_sequencer (STEP=4, DIV=8, DWELL=16, WDT=64).
// Build with MOTOR_CMD_WDT_EN defined to exercise the watchdog path.
module tb_motor_ramp_sequencer;
    import motor_ramp_sequencer_pkg::*;

    localparam int unsigned DW = 10;

    logic          clock = 1'b0;
    logic          reset_n;
    logic          fault_in;
    logic          fault_clear;
    logic [DW-1:0] duty_cycle;
    logic          dir;
    logic [2:0]    state;
    logic          fault_latched;
    logic          wdt_timeout;

    int tests = 0;
    int fails = 0;

    motor_ramp_sequencer_if #(.DUTY_W(DW)) cmd_if ();

    motor_ramp_sequencer #(
        .DUTY_W(DW), .RAMP_STEP(4), .RAMP_DIV(8), .DWELL_CYCLES(16), .WDT_CYCLES(64)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .cmd          (cmd_if),
        .fault_in     (fault_in),
        .fault_clear  (fault_clear),
        .duty_cycle   (duty_cycle),
        .dir          (dir),
        .state        (state),
        .fault_latched(fault_latched),
        .wdt_timeout  (wdt_timeout)
    );

    always #5 clock = ~clock;

    task automatic cyc(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input int unsigned d, input logic r);
        cmd_if.cmd_valid = 1'b1;
        cmd_if.cmd_duty  = DW'(d);
        cmd_if.cmd_dir   = r;
    endtask

    initial begin
        bit wdt_seen;
        int exp_d;
        reset_n = 1'b0; fault_in = 1'b0; fault_clear = 1'b0;
        cmd_if.cmd_valid = 1'b0; cmd_if.cmd_duty = '0; cmd_if.cmd_dir = 1'b0;

        // Reset values
        cyc(2);
        chk("rst_state", 32'(state), 0);
        chk("rst_duty", 32'(duty_cycle), 0);
        chk("rst_dir", 32'(dir), 0);
        chk("rst_fault", 32'(fault_latched), 0);
        chk("rst_wdt", 32'(wdt_timeout), 0);
        chk("rst_ready", 32'(cmd_if.cmd_ready), 0);
        reset_n = 1'b1;
        cyc(1);
        chk("ready_after_rst", 32'(cmd_if.cmd_ready), 1);

        // Ramp up 0 -> 100, dir 0
        send(100, 1'b0);
        cyc(1);
        chk("A_accept_idle", 32'(state), 0);
        cyc(1);
        chk("A_enter_ramp", 32'(state), 1);
        for (int k = 1; k <= 25; k++) begin
            cyc(7);
            chk($sformatf("A_hold%0d", k), 32'(duty_cycle), 32'(4 * (k - 1)));
            cyc(1);
            chk($sformatf("A_tick%0d", k), 32'(duty_cycle), 32'(4 * k));
        end
        chk("A_run", 32'(state), 2);
        chk("A_dir", 32'(dir), 0);

        // Reverse to 40 dir 1 through DWELL
        send(40, 1'b1);
        cyc(1);
        chk("B_accept_run", 32'(state), 2);
        cyc(1);
        chk("B_ramp", 32'(state), 1);
        chk("B_ramp_duty", 32'(duty_cycle), 100);
        for (int k = 1; k <= 25; k++) begin
            cyc(7);
            chk($sformatf("B_dn_hold%0d", k), 32'(duty_cycle), 32'(100 - 4 * (k - 1)));
            cyc(1);
            chk($sformatf("B_dn_tick%0d", k), 32'(duty_cycle), 32'(100 - 4 * k));
            chk($sformatf("B_dn_dir%0d", k), 32'(dir), 0);
        end
        chk("B_dwell", 32'(state), 3);
        cyc(15);
        chk("B_dwell_end_state", 32'(state), 3);
        chk("B_dwell_end_dir", 32'(dir), 0);
        chk("B_dwell_end_duty", 32'(duty_cycle), 0);
        cyc(1);
        chk("B_exit_state", 32'(state), 1);
        chk("B_exit_dir", 32'(dir), 1);
        for (int k = 1; k <= 10; k++) begin
            cyc(7);
            chk($sformatf("B_up_hold%0d", k), 32'(duty_cycle), 32'(4 * (k - 1)));
            cyc(1);
            chk($sformatf("B_up_tick%0d", k), 32'(duty_cycle), 32'(4 * k));
        end
        chk("B_run", 32'(state), 2);
        chk("B_run_dir", 32'(dir), 1);

        // Down to 0 (IDLE), then 0 -> 102 with exact saturation
        send(0, 1'b1);
        cyc(2);
        cyc(80);
        chk("C_idle", 32'(state), 0);
        chk("C_idle_duty", 32'(duty_cycle), 0);
        send(102, 1'b1);
        cyc(2);
        chk("C_ramp", 32'(state), 1);
        for (int k = 1; k <= 26; k++) begin
            cyc(7);
            exp_d = (4 * (k - 1) > 102) ? 102 : 4 * (k - 1);
            chk($sformatf("C_hold%0d", k), 32'(duty_cycle), 32'(exp_d));
            cyc(1);
            exp_d = (4 * k > 102) ? 102 : 4 * k;
            chk($sformatf("C_tick%0d", k), 32'(duty_cycle), 32'(exp_d));
        end
        chk("C_run", 32'(state), 2);

        // Ramp down 102 -> 0 saturating at target, then fault at duty 60
        send(0, 1'b1);
        cyc(2);
        cyc(208);
        chk("D_idle", 32'(state), 0);
        chk("D_idle_duty", 32'(duty_cycle), 0);
        send(100, 1'b1);
        cyc(2);
        cyc(120);
        chk("D_pre_fault_duty", 32'(duty_cycle), 60);
        chk("D_pre_fault_state", 32'(state), 1);
        fault_in = 1'b1;
        send(200, 1'b0);
        #1;
        chk("D_ready_fault_in", 32'(cmd_if.cmd_ready), 0);
        cyc(1);
        chk("D_fault_state", 32'(state), 4);
        chk("D_fault_duty", 32'(duty_cycle), 0);
        chk("D_fault_dir", 32'(dir), 1);
        chk("D_fault_latched", 32'(fault_latched), 1);
        fault_clear = 1'b1;
        cyc(1);
        chk("D_clear_ignored", 32'(state), 4);
        fault_in = 1'b0; fault_clear = 1'b0; cmd_if.cmd_valid = 1'b0;
        cyc(1);
        chk("D_still_fault", 32'(state), 4);
        chk("D_ready_in_fault", 32'(cmd_if.cmd_ready), 0);
        fault_clear = 1'b1;
        cyc(1);
        chk("D_cleared", 32'(state), 0);
        chk("D_unlatched", 32'(fault_latched), 0);
        chk("D_ready_back", 32'(cmd_if.cmd_ready), 1);
        fault_clear = 1'b0;
        cyc(4);
        chk("D_target_zeroed", 32'(state), 0);
        chk("D_dir_kept", 32'(dir), 1);

        // Reset in the middle of DWELL
        send(20, 1'b0);
        cyc(3);
        chk("E_dwell", 32'(state), 3);
        cyc(5);
        chk("E_dwell_dir", 32'(dir), 1);
        reset_n = 1'b0;
        cmd_if.cmd_valid = 1'b0;
        #1;
        chk("E_ready_in_rst", 32'(cmd_if.cmd_ready), 0);
        cyc(1);
        chk("E_rst_state", 32'(state), 0);
        chk("E_rst_duty", 32'(duty_cycle), 0);
        chk("E_rst_dir", 32'(dir), 0);
        chk("E_rst_fault", 32'(fault_latched), 0);
        chk("E_rst_wdt", 32'(wdt_timeout), 0);
        reset_n = 1'b1;
        cyc(20);
        chk("E_after_state", 32'(state), 0);
        chk("E_after_dir", 32'(dir), 0);
        chk("E_after_duty", 32'(duty_cycle), 0);

        // Watchdog behaviour from RUN at 100 with command port silent
        send(100, 1'b0);
        cyc(202);
        chk("F_run", 32'(state), 2);
        chk("F_run_duty", 32'(duty_cycle), 100);
        cmd_if.cmd_valid = 1'b0;
`ifdef MOTOR_CMD_WDT_EN
        cyc(63);
        chk("F_wdt_quiet", 32'(wdt_timeout), 0);
        cyc(1);
        chk("F_wdt_pulse", 32'(wdt_timeout), 1);
        cyc(1);
        chk("F_wdt_one_cycle", 32'(wdt_timeout), 0);
        chk("F_ramp_down", 32'(state), 1);
        cyc(200);
        chk("F_wdt_idle", 32'(state), 0);
        chk("F_wdt_duty", 32'(duty_cycle), 0);
`else
        wdt_seen = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            cyc(1);
            if (wdt_timeout !== 1'b0 || duty_cycle !== DW'(100)) wdt_seen = 1'b1;
        end
        chk("F_hold_1000", 32'(wdt_seen), 0);
        chk("F_hold_duty", 32'(duty_cycle), 100);
        chk("F_hold_state", 32'(state), 2);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/motor_ramp_sequencer.md
MOTOR_RAMP_SEQUENCER -- requirements
Module: motor_ramp_sequencer

Interface
REQ-001 Parameter DUTY_W, default `DUTY_CYCLE_WIDTH (10): duty width, matching the phase drivers.
REQ-002 Parameter RAMP_STEP, default 4: duty change per ramp tick.
REQ-003 Parameter RAMP_DIV, default 250: clock cycles per ramp tick, minimum 1.
REQ-004 Parameter DWELL_CYCLES, default 1024: zero-duty dwell before a direction flip.
REQ-005 Parameter WDT_CYCLES, default 2000000: command watchdog timeout.
REQ-006 clock  in  1: single clock for the whole block.
REQ-007 reset_n  in  1: synchronous, active-low reset.
REQ-008 cmd_valid/cmd_ready  in/out  1/1: command handshake; a transfer occurs when both are high on a rising edge.
REQ-009 cmd_duty  in  DUTY_W: target magnitude.
REQ-010 cmd_dir  in  1: target direction.
REQ-011 fault_in  in  1: fault from the motor driver.
REQ-012 fault_clear  in  1: single-cycle request to leave FAULT.
REQ-013 duty_cycle  out  DUTY_W: registered duty to the motor driver.
REQ-014 dir  out  1: registered direction to the motor driver.
REQ-015 state  out  3: current state encoding.
REQ-016 fault_latched  out  1: high while in FAULT.
REQ-017 wdt_timeout  out  1: one-cycle pulse on watchdog expiry.

Function
REQ-018 States: IDLE=0, RAMP=1, RUN=2, DWELL=3, FAULT=4; all other codes go to IDLE.
REQ-019 cmd_ready = (state != FAULT) && !fault_in.
- An accepted command loads target_duty and target_dir on that edge.
- A newer command overwrites the older one; there is no queue.
REQ-020 Ramp tick: a prescaler pulses once every RAMP_DIV cycles while in RAMP and is cleared on entering RAMP.
REQ-021 IDLE/RUN: on a target differing from (duty_cycle, dir), go to RAMP next cycle.
REQ-022 RAMP, same direction, on a tick: duty_cycle moves toward target_duty by RAMP_STEP and saturates exactly at the target, with no overshoot and no wrap.
- When duty_cycle equals target: go to RUN, or to IDLE if the target is 0.
REQ-023 RAMP, direction differs, on a tick: duty_cycle decrements by RAMP_STEP, saturating at 0.
- When duty_cycle reaches 0: go to DWELL.
REQ-024 DWELL holds duty_cycle=0 for exactly DWELL_CYCLES cycles, then sets dir to target_dir and moves to RAMP, or to IDLE if target_duty is 0.
- Commands accepted during DWELL update the target but do not shorten the dwell.
REQ-025 dir changes only at DWELL exit and is never changed while duty_cycle != 0.
REQ-026 fault_in high on any edge (any state) forces the next cycle to: duty_cycle=0, state FAULT, target_duty=0; dir is held.
- A command accepted on the same edge is discarded.
REQ-027 FAULT exits to IDLE on the edge where fault_clear=1 and fault_in=0; fault_clear is otherwise ignored.
REQ-028 Duty arithmetic uses DUTY_W+1 bits internally; the output never exceeds 2^DUTY_W-1.

Reset
REQ-029 With reset_n low on an edge: state=IDLE, duty_cycle=0, dir=0, target=0, all counters=0, fault_latched=0, wdt_timeout=0.
- Reset mid-RAMP or mid-DWELL gives exactly the same values.
REQ-030 cmd_ready is low while reset_n is low.

Configuration
REQ-031 With MOTOR_CMD_WDT_EN defined:
- A counter is cleared on every accepted command.
- On reaching WDT_CYCLES outside FAULT, it pulses wdt_timeout, sets target_duty=0 (a normal ramp-down, not an abrupt stop) and restarts.
REQ-032 With MOTOR_CMD_WDT_EN undefined: no watchdog logic; wdt_timeout is tied to 0 and the target holds indefinitely.

Structure
REQ-033 Shared header/package holds the state encoding localparams, the DUTY_CYCLE_WIDTH default and the MOTOR_CMD_WDT_EN guard documentation.
REQ-034 The prescaler is a sub-module, ramp_tick_gen (counter plus tick pulse, with clear); all else stays in motor_ramp_sequencer.

Verification (bench: RAMP_STEP=4, RAMP_DIV=8, DWELL_CYCLES=16, WDT_CYCLES=64)
REQ-035 Reset, then command 100/dir0 -> duty rises 4 per 8 cycles, reaches 100 after 25 ticks, state=RUN, dir stays 0.
REQ-036 From RUN 100/dir0, command 40/dir1 -> ramp to 0 in 25 ticks, 16 cycles at duty 0 in DWELL, dir=1, ramp to 40 in 10 ticks.
REQ-037 Command 102 from 0 -> ticks give 4,8,...,100, then 102, then RUN; no value exceeds 102.
REQ-038 fault_in pulse at duty 60 in RAMP -> next cycle duty 0, FAULT, cmd_ready 0; fault_clear with fault_in high is ignored; fault_clear after fault_in drops -> IDLE.
REQ-039 WDT enabled, RUN at 100 with no commands -> wdt_timeout pulses at cycle 64, duty ramps to 0, IDLE; macro undefined -> duty holds 100 for 1000 cycles.
REQ-040 reset_n low for one cycle mid-DWELL -> all REQ-029 values on the next cycle, no dir change afterwards.
